// File: rtl/coraz7_led_btn_ctrl.sv
// Cora Z7 board I/O: button debounce, RGB LED ownership (core vs heartbeat) and per-channel PWM.
// Optional macro CORAZ7_LED_BTN_CTRL_BTN_OVERRIDE_EN: debounced button 1 forces heartbeat ownership.
module coraz7_led_btn_ctrl #(
    parameter int PWM_BITS        = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int OWN_TIMEOUT     = 50000000,
    parameter int HB_BIT          = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            btn,
    output logic [1:0]            btn_state,
    output logic [1:0]            btn_press,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_led,
    input  logic [3*PWM_BITS-1:0] wr_rgb,
    output logic                  core_owns,
    output logic                  dbg_fsm,
    output logic                  led0_r,
    output logic                  led0_g,
    output logic                  led0_b,
    output logic                  led1_r,
    output logic                  led1_g,
    output logic                  led1_b
);

    localparam int DW   = 3 * PWM_BITS;
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TO_W = (OWN_TIMEOUT > 1) ? $clog2(OWN_TIMEOUT) : 1;

    localparam logic [0:0] ST_HB   = 1'b0;
    localparam logic [0:0] ST_CORE = 1'b1;

    localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;
    localparam logic [PWM_BITS-1:0] DUTY_OFF  = '0;

    // Handshake: a write transfers in any cycle where wr_valid && wr_ready; wr_ready is low
    // only while the addressed LED still has an uncommitted shadow value waiting for a wrap.

    logic [1:0]                 sync1_q, sync2_q;
    logic [1:0][DB_W-1:0]       db_cnt_q, db_cnt_d;
    logic [1:0]                 btn_state_q, btn_state_d;
    logic [1:0]                 btn_press_q, btn_press_d;

    logic [PWM_BITS-1:0]        pwm_cnt_q;
    logic [HB_BIT:0]            hb_q;
    logic                       wrap;

    logic [1:0][DW-1:0]         shadow_q, shadow_d;
    logic [1:0][DW-1:0]         core_duty_q, core_duty_d;
    logic [1:0][DW-1:0]         act_q, act_d;
    logic [1:0]                 pend_q, pend_d;
    logic                       accept;

    logic [0:0]                 fsm_q, fsm_d;
    logic [0:0]                 src_q, src_d;
    logic [TO_W-1:0]            to_cnt_q, to_cnt_d;

    assign wrap     = &pwm_cnt_q;
    assign wr_ready = ~pend_q[wr_led];
    assign accept   = wr_valid & wr_ready;

    always_comb begin
        btn_state_d = btn_state_q;
        db_cnt_d    = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == btn_state_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_state_d[i] = sync2_q[i];
                db_cnt_d[i]    = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
        btn_press_d = btn_state_d & ~btn_state_q;
    end

    // Pending shadows commit only on the wrap cycle, so a period always uses one duty value.
    always_comb begin
        shadow_d    = shadow_q;
        pend_d      = pend_q;
        core_duty_d = core_duty_q;
        if (wrap) begin
            for (int l = 0; l < 2; l++) begin
                if (pend_q[l]) begin
                    core_duty_d[l] = shadow_q[l];
                    pend_d[l]      = 1'b0;
                end
            end
        end
        if (accept) begin
            shadow_d[wr_led] = wr_rgb;
            pend_d[wr_led]   = 1'b1;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        to_cnt_d = to_cnt_q;
        if (accept) begin
            to_cnt_d = TO_W'(OWN_TIMEOUT - 1);
        end else if (fsm_q == ST_CORE && to_cnt_q != '0) begin
            to_cnt_d = to_cnt_q - 1'b1;
        end
        case (fsm_q)
            ST_HB:   if (accept) fsm_d = ST_CORE;
            ST_CORE: if (!accept && to_cnt_q == '0) fsm_d = ST_HB;
            default: fsm_d = ST_HB;
        endcase
`ifdef CORAZ7_LED_BTN_CTRL_BTN_OVERRIDE_EN
        if (btn_state_q[1]) begin
            fsm_d = ST_HB;
        end
`else
`endif
    end

    // The displayed source follows the ownership FSM only at a wrap, together with any commit.
    always_comb begin
        src_d = src_q;
        act_d = act_q;
        if (wrap) begin
            src_d = fsm_q;
            if (fsm_q == ST_CORE) begin
                act_d = core_duty_d;
            end else begin
                act_d[0] = {DUTY_OFF, hb_q[HB_BIT] ? DUTY_FULL : DUTY_OFF, DUTY_OFF};
                act_d[1] = {hb_q[HB_BIT] ? DUTY_OFF : DUTY_FULL, DUTY_OFF, DUTY_OFF};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_cnt_q    <= '0;
            btn_state_q <= '0;
            btn_press_q <= '0;
            pwm_cnt_q   <= '0;
            hb_q        <= '0;
            shadow_q    <= '0;
            core_duty_q <= '0;
            act_q       <= '0;
            pend_q      <= '0;
            fsm_q       <= ST_HB;
            src_q       <= ST_HB;
            to_cnt_q    <= '0;
        end else begin
            sync1_q     <= btn;
            sync2_q     <= sync1_q;
            db_cnt_q    <= db_cnt_d;
            btn_state_q <= btn_state_d;
            btn_press_q <= btn_press_d;
            pwm_cnt_q   <= pwm_cnt_q + 1'b1;
            hb_q        <= hb_q + 1'b1;
            shadow_q    <= shadow_d;
            core_duty_q <= core_duty_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            fsm_q       <= fsm_d;
            src_q       <= src_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign btn_state = btn_state_q;
    assign btn_press = btn_press_q;
    assign core_owns = (src_q == ST_CORE);
    assign dbg_fsm   = (fsm_q == ST_CORE);

    assign led0_r = pwm_cnt_q < act_q[0][DW-1 -: PWM_BITS];
    assign led0_g = pwm_cnt_q < act_q[0][2*PWM_BITS-1 -: PWM_BITS];
    assign led0_b = pwm_cnt_q < act_q[0][PWM_BITS-1 -: PWM_BITS];
    assign led1_r = pwm_cnt_q < act_q[1][DW-1 -: PWM_BITS];
    assign led1_g = pwm_cnt_q < act_q[1][2*PWM_BITS-1 -: PWM_BITS];
    assign led1_b = pwm_cnt_q < act_q[1][PWM_BITS-1 -: PWM_BITS];

endmodule
